// File: rtl/mw_add_sub_seq.sv
// Multi-word add/subtract sequencer: streams WORDS chunks of N bits through an external N-bit add/sub stage.
// Optional zero_o result flag is built when MW_ADD_SUB_SEQ_ZERO_FLAG_EN is defined.
module mw_add_sub_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*WORDS-1:0]   a_i,
    input  logic [N*WORDS-1:0]   b_i,
    input  logic                 sub_i,
    output logic [N-1:0]         add_a_o,
    output logic [N-1:0]         add_b_o,
    output logic                 add_c_o,
    input  logic [N-1:0]         add_s_i,
    input  logic                 add_c_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N*WORDS-1:0]   s_o,
    output logic                 c_o,
`ifdef MW_ADD_SUB_SEQ_ZERO_FLAG_EN
    output logic                 ovf_o,
    output logic                 zero_o
`else
    output logic                 ovf_o
`endif
);

    localparam int W  = N * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_ovf;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_a_chunk;
    logic [N-1:0]    w_beff;
    logic            w_last;
    logic            w_accept;
    logic            w_consume;

    // Current chunk of each operand; beff is the effective B (inverted for subtraction).
    assign w_a_chunk = r_a[r_cnt*N +: N];
    assign w_beff    = r_sub ? ~r_b[r_cnt*N +: N] : r_b[r_cnt*N +: N];
    assign w_last    = (r_cnt == CW'(WORDS - 1));

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_consume   = out_valid_o & out_ready_i;

    assign s_o   = r_sum;
    assign c_o   = r_carry;
    assign ovf_o = r_ovf;

`ifdef MW_ADD_SUB_SEQ_ZERO_FLAG_EN
    assign zero_o = out_valid_o & (r_sum == '0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        add_a_o     = '0;
        add_b_o     = '0;
        add_c_o     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // The downstream stage XORs its B input with its carry-in, so pre-invert to cancel that.
                add_a_o = w_a_chunk;
                add_b_o = w_beff ^ {N{r_carry}};
                add_c_o = r_carry;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_consume) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_sub   <= sub_i;
                        r_sum   <= '0;
                        r_ovf   <= 1'b0;
                        r_carry <= sub_i;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_cnt*N +: N] <= add_s_i;
                    r_carry             <= add_c_i;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_ovf <= (r_a[W-1] == w_beff[N-1]) & (add_s_i[N-1] != r_a[W-1]);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mw_add_sub_seq.sv
// Self-checking bench for mw_add_sub_seq: models the external N-bit stage and checks against plain arithmetic.
module tb_mw_add_sub_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         sub_i;
    logic [N-1:0] add_a_o;
    logic [N-1:0] add_b_o;
    logic         add_c_o;
    logic [N-1:0] add_s_i;
    logic         add_c_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] s_o;
    logic         c_o;
    logic         ovf_o;
`ifdef MW_ADD_SUB_SEQ_ZERO_FLAG_EN
    logic         zero_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mw_add_sub_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .sub_i       (sub_i),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_c_o     (add_c_o),
        .add_s_i     (add_s_i),
        .add_c_i     (add_c_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .s_o         (s_o),
        .c_o         (c_o),
`ifdef MW_ADD_SUB_SEQ_ZERO_FLAG_EN
        .ovf_o       (ovf_o),
        .zero_o      (zero_o)
`else
        .ovf_o       (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // External stage: inverts B by its carry-in, then adds with carry-in.
    always_comb begin
        logic [N:0] full;
        full = {1'b0, add_a_o} + {1'b0, add_b_o ^ {N{add_c_o}}} + {{N{1'b0}}, add_c_o};
        add_s_i = full[N-1:0];
        add_c_i = full[N];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference result from signed/unsigned integer arithmetic.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                             output logic [W-1:0] s, output logic c, output logic ovf);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            s = W'(ua - ub);
            c = (ua >= ub);
            r = sa - sb;
        end else begin
            s = W'(ua + ub);
            c = (ua + ub) >= (1 << W);
            r = sa + sb;
        end
        ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
        logic [W-1:0] exp_s;
        logic         exp_c;
        logic         exp_ovf;
        logic [N-1:0] exp_b0;
        int           lat;
        ref_model(a, b, sub, exp_s, exp_c, exp_ovf);
        exp_b0 = sub ? (~b[N-1:0]) ^ {N{1'b1}} : b[N-1:0];
        check("ready_before_req", 32'(in_ready_o), 32'd1);
        a_i = a; b_i = b; sub_i = sub; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 1;
        check("k0_add_a", 32'(add_a_o), 32'(a[N-1:0]));
        check("k0_add_b", 32'(add_b_o), 32'(exp_b0));
        check("k0_add_c", 32'(add_c_o), 32'(sub));
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(WORDS + 1));
        check("sum", 32'(s_o), 32'(exp_s));
        check("carry", 32'(c_o), 32'(exp_c));
        check("ovf", 32'(ovf_o), 32'(exp_ovf));
        check("ready_in_done", 32'(in_ready_o), 32'd0);
        check("done_add_drive", {add_a_o, add_b_o, add_c_o}, 32'd0);
`ifdef MW_ADD_SUB_SEQ_ZERO_FLAG_EN
        check("zero", 32'(zero_o), 32'(exp_s == '0));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'b1;
            a_i = W'($urandom);
            b_i = W'($urandom);
            sub_i = 1'($urandom);
            @(posedge clk_i); #1;
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check("bp_ready", 32'(in_ready_o), 32'd0);
            check("bp_stable", {15'd0, c_o, ovf_o, s_o}, {15'd0, exp_c, exp_ovf, exp_s});
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        check("ready_after_consume", 32'(in_ready_o), 32'd1);
        check("valid_after_consume", 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        a_i = '0; b_i = '0; sub_i = 1'b0;
        #2;
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_result", {15'd0, c_o, ovf_o, s_o}, 32'd0);
        check("rst_add_drive", {add_a_o, add_b_o, add_c_o}, 32'd0);
        #20 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_op(16'h00FF, 16'h0001, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b1, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 3);

        // Reset asserted during chunk 2 of an operation.
        a_i = 16'hABCD; b_i = 16'h5678; sub_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        check("pre_rst_running", 32'(add_a_o), 32'hB);
        rst_ni = 1'b0;
        #1;
        check("midrun_rst_ready", 32'(in_ready_o), 32'd1);
        check("midrun_rst_valid", 32'(out_valid_o), 32'd0);
        check("midrun_rst_result", {15'd0, c_o, ovf_o, s_o}, 32'd0);
        check("midrun_rst_add", {add_a_o, add_b_o, add_c_o}, 32'd0);
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_idle", 32'(in_ready_o), 32'd1);
        do_op(16'h1234, 16'h1111, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mw_add_sub_seq.md
MW_ADD_SUB_SEQ -- requirements
Module: mw_add_sub_seq

Interface
REQ-001 Parameter N, default 4: width in bits of one adder chunk.
REQ-002 Parameter WORDS, default 4: number of chunks per operand; operand width W = N*WORDS.
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 in_valid_i  in  1  request present.
REQ-007 in_ready_o  out  1  block can accept a request.
REQ-008 a_i  in  W  operand A.
REQ-009 b_i  in  W  operand B.
REQ-010 sub_i  in  1  operation select: 1 = A-B, 0 = A+B.
REQ-011 add_a_o  out  N  A chunk driven to the external N-bit add/sub stage.
REQ-012 add_b_o  out  N  B chunk driven to that stage.
REQ-013 add_c_o  out  1  carry/subtract input driven to that stage.
REQ-014 add_s_i  in  N  chunk sum returned by that stage.
REQ-015 add_c_i  in  1  chunk carry-out returned by that stage.
REQ-016 out_valid_o  out  1  result valid.
REQ-017 out_ready_i  in  1  consumer accepts the result.
REQ-018 s_o  out  W  result.
REQ-019 c_o  out  1  final carry-out; for subtraction, 1 = no borrow.
REQ-020 ovf_o  out  1  two's-complement signed overflow.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-022 in_ready_o SHALL be 1 only in IDLE; it is decoded from state.
REQ-023 A request SHALL be accepted when in_valid_i & in_ready_o are both 1 in cycle T. On acceptance, a_i, b_i and sub_i are latched, the chunk counter is cleared, carry is set to sub_i, and the FSM goes to RUN.
REQ-024 In RUN, chunk k (k = 0..WORDS-1) SHALL be driven in cycle T+1+k as follows: add_a_o = A[k], beff = sub ? ~B[k] : B[k], add_c_o = carry, add_b_o = beff XOR {N{carry}}. This compensates for the downstream stage inverting its B input by its carry-in.
REQ-025 At the end of each RUN cycle, add_s_i SHALL be stored into result chunk k and carry SHALL be updated to add_c_i.
REQ-026 After chunk WORDS-1 the FSM SHALL go to DONE. out_valid_o is asserted from cycle T+WORDS+1, so latency is WORDS+1 cycles.
REQ-027 c_o SHALL equal the final carry.
REQ-028 ovf_o SHALL be computed as (A msb == beff msb of the top chunk) & (s msb != A msb).
REQ-029 In DONE, s_o, c_o and ovf_o SHALL hold stable until out_valid_o & out_ready_i; the FSM then returns to IDLE on the next edge.
REQ-030 A request SHALL never be accepted in the same cycle a result is consumed. in_valid_i seen outside IDLE is ignored and not queued.
REQ-031 add_a_o, add_b_o and add_c_o SHALL be 0 in IDLE and DONE.
REQ-032 Arithmetic SHALL be modulo 2^W; no saturation.

Reset
REQ-033 While rst_ni is 0, and immediately on its assertion (including mid-RUN or in DONE), the block SHALL be in IDLE. All of the following are 0: out_valid_o, s_o, c_o, ovf_o, add_* outputs, latched operands, carry and counter.
REQ-034 in_ready_o SHALL read 1 during and after reset, since the state is IDLE.
REQ-035 Any in-flight operation SHALL be discarded on reset; no partial result is produced.

Configuration
REQ-036 With macro MW_ADD_SUB_SEQ_ZERO_FLAG_EN defined, the block SHALL add output zero_o (1 bit). zero_o = 1 when s_o == 0 while out_valid_o is 1, otherwise 0, and it resets to 0.
REQ-037 Without the macro, the zero_o port and its logic SHALL be absent; all other behaviour is identical.

Verification (N=4, WORDS=4, W=16)
REQ-038 Carry across chunks: A=0x00FF, B=0x0001, sub=0 -> s_o=0x0100, c_o=0, ovf_o=0. out_valid_o rises exactly 5 cycles after acceptance.
REQ-039 Borrow: A=0x0000, B=0x0001, sub=1 -> s_o=0xFFFF, c_o=0, ovf_o=0. At k=0, add_c_o=1 and add_b_o=0x1.
REQ-040 Signed overflow: A=0x7FFF, B=0x0001, sub=0 -> s_o=0x8000, c_o=0, ovf_o=1. Also A=0x8000, B=0x0001, sub=1 -> s_o=0x7FFF, c_o=1, ovf_o=1.
REQ-041 Wrap: A=0xFFFF, B=0x0001, sub=0 -> s_o=0x0000, c_o=1, ovf_o=0; zero_o=1 when the macro is defined.
REQ-042 Backpressure: hold out_ready_i=0 for 3 cycles in DONE while in_valid_i=1 with new operands. Outputs stay stable, in_ready_o=0, and no new request is accepted; in_ready_o=1 the cycle after consumption.
REQ-043 Reset mid-RUN: assert rst_ni=0 at chunk 2. All outputs go to 0 asynchronously, with in_ready_o=1. A subsequent request 0x1234+0x1111 yields 0x2345.
